// File: rtl/funcPckg.sv
// rtl/funcPckg.sv - shared helper functions used across the im2col slice
package funcPckg;

  // Ceiling log2, so a power-of-two size yields its exponent.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/im2ColPckg.sv
// rtl/im2ColPckg.sv - im2col request types plus the frame scheduler's state and config
package im2ColPckg;

  localparam int cImgMax      = 64;
  localparam int cAddrW       = funcPckg::log2(cImgMax);
  localparam int cMaxKerWidth = 8;
  localparam int cKerW        = funcPckg::log2(cMaxKerWidth) + 1;
  localparam int cWdogCycles  = 16;
  localparam int cWdogW       = funcPckg::log2(cWdogCycles) + 1;

  typedef struct packed {
    logic              dv;
    logic [cAddrW-1:0] x;
    logic [cAddrW-1:0] y;
    logic [cKerW-1:0]  kerWidth;
  } tIm2ColIn;

  typedef enum logic [1:0] {
    sIdle,
    sIssue,
    sWait,
    sFin
  } tSchedState;

  typedef struct packed {
    logic [cAddrW:0]  imgW;
    logic [cAddrW:0]  imgH;
    logic [cKerW-1:0] kerWidth;
    logic [1:0]       stride;
  } tSchedCfg;

endpackage

// File: rtl/win_stepper.sv
// rtl/win_stepper.sv - raster window position register with next-x/next-y/last-window logic
module win_stepper
  import im2ColPckg::*;
(
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iClear,
  input  logic              iStep,
  input  tSchedCfg          iCfg,
  output logic [cAddrW-1:0] oX,
  output logic [cAddrW-1:0] oY,
  output logic              oLast
);

  // Two extra bits keep position + stride + kernel from wrapping at the image edge.
  localparam int cCmpW = cAddrW + 2;

  logic [cCmpW-1:0] xEnd;
  logic [cCmpW-1:0] yEnd;
  logic             xFits;
  logic             yFits;

  always_comb begin
    xEnd  = cCmpW'(oX) + cCmpW'(iCfg.stride) + cCmpW'(iCfg.kerWidth);
    yEnd  = cCmpW'(oY) + cCmpW'(iCfg.stride) + cCmpW'(iCfg.kerWidth);
    xFits = (xEnd <= cCmpW'(iCfg.imgW));
    yFits = (yEnd <= cCmpW'(iCfg.imgH));
    oLast = !xFits && !yFits;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oX <= '0;
      oY <= '0;
    end else if (iClear) begin
      oX <= '0;
      oY <= '0;
    end else if (iStep) begin
      if (xFits) begin
        oX <= oX + cAddrW'(iCfg.stride);
      end else if (yFits) begin
        oX <= '0;
        oY <= oY + cAddrW'(iCfg.stride);
      end
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// rtl/conv_window_sched.sv - frame scheduler issuing one im2col request per kernel window position
module conv_window_sched
  import im2ColPckg::*;
(
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic [cAddrW:0]   iImgW,
  input  logic [cAddrW:0]   iImgH,
  input  logic [cKerW-1:0]  iKerWidth,
  input  logic [1:0]        iStride,
  output logic              oReqDv,
  output logic [cAddrW-1:0] oReqX,
  output logic [cAddrW-1:0] oReqY,
  output logic [cKerW-1:0]  oReqKerWidth,
  input  logic              iIm2ColDone,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oCfgErr,
  output logic              oWdogErr,
  output logic [15:0]       oWinCount
);

  tSchedState        state;
  tSchedState        stateNxt;
  tSchedCfg          cfg;
  tIm2ColIn          req;
  logic [cWdogW-1:0] wdogCnt;
  logic [15:0]       winCount;
  logic              wdogErr;
  logic              cfgErr;
  logic              cfgValid;
  logic              accept;
  logic              reject;
  logic              doneOk;
  logic              wdogTimeout;
  logic              winLast;
  logic [cAddrW-1:0] winX;
  logic [cAddrW-1:0] winY;

  win_stepper uStepper (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iClear (accept),
    .iStep  (doneOk && !winLast),
    .iCfg   (cfg),
    .oX     (winX),
    .oY     (winY),
    .oLast  (winLast)
  );

  always_comb begin
    cfgValid = (iKerWidth >= cKerW'(1)) && (iKerWidth <= cKerW'(cMaxKerWidth)) &&
               (iStride != 2'd0) &&
               ((cAddrW+1)'(iKerWidth) <= iImgW) && ((cAddrW+1)'(iKerWidth) <= iImgH);
    accept      = (state == sIdle) && iStart && !iAbort && cfgValid;
    reject      = (state == sIdle) && iStart && !iAbort && !cfgValid;
    doneOk      = (state == sWait) && iIm2ColDone && !iAbort;
    wdogTimeout = (state == sWait) && !iIm2ColDone && !iAbort && (wdogCnt == '0);

    stateNxt = state;
    if (iAbort) begin
      stateNxt = sIdle;
    end else begin
      case (state)
        sIdle:   if (accept) stateNxt = sIssue;
        sIssue:  stateNxt = sWait;
        sWait: begin
          if (iIm2ColDone)      stateNxt = winLast ? sFin : sIssue;
          else if (wdogTimeout) stateNxt = sIdle;
        end
        sFin:    stateNxt = sIdle;
        default: stateNxt = sIdle;
      endcase
    end

    // Abort masks the strobes combinationally so nothing escapes in the abort cycle.
    req.dv       = (state == sIssue) && !iAbort;
    req.x        = winX;
    req.y        = winY;
    req.kerWidth = cfg.kerWidth;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= sIdle;
      cfg      <= '0;
      wdogCnt  <= '0;
      winCount <= '0;
      wdogErr  <= 1'b0;
      cfgErr   <= 1'b0;
    end else begin
      state  <= stateNxt;
      cfgErr <= reject;
      if (accept) begin
        cfg.imgW     <= iImgW;
        cfg.imgH     <= iImgH;
        cfg.kerWidth <= iKerWidth;
        cfg.stride   <= iStride;
        winCount     <= '0;
        wdogErr      <= 1'b0;
      end
      if (state == sIssue) wdogCnt <= cWdogW'(cWdogCycles - 1);
      else if (state == sWait && wdogCnt != '0) wdogCnt <= wdogCnt - cWdogW'(1);
      if (doneOk) winCount <= winCount + 16'd1;
      if (wdogTimeout) wdogErr <= 1'b1;
    end
  end

  assign oReqDv       = req.dv;
  assign oReqX        = req.x;
  assign oReqY        = req.y;
  assign oReqKerWidth = req.kerWidth;
  assign oBusy        = (state != sIdle);
  assign oFrameDone   = (state == sFin) && !iAbort;
  assign oCfgErr      = cfgErr;
  assign oWdogErr     = wdogErr;
  assign oWinCount    = winCount;

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Frame-level scheduler for the im2col address generator. It walks a kernel window across an input feature map in raster order, x first then y, with a programmable stride. For each window position it issues one request (start X, start Y, kernel width) to im2col and waits for that unit's done pulse before issuing the next. It sits between the layer-config registers and im2col, and owns frame start, frame completion, abort, watchdog and error reporting.

## Interface
- cImgMax, 64: maximum image width/height in pixels; cAddrW = log2(cImgMax).
- cMaxKerWidth, 8: maximum kernel width, shared with im2col; cKerW = log2(cMaxKerWidth)+1.
- cWdogCycles, 16: cycles allowed between a request and im2col done.
- iClk  in  1  clock.
- iRstN  in  1  asynchronous, active-low reset.
- iStart  in  1  frame start pulse; sampled only in IDLE.
- iAbort  in  1  abort the frame; takes priority over everything except reset.
- iImgW, iImgH  in  cAddrW+1  image dimensions, 1..cImgMax.
- iKerWidth  in  cKerW  kernel width, 1..cMaxKerWidth.
- iStride  in  2  stride, 1..3.
- oReqDv  out  1  one-cycle request strobe to im2col.
- oReqX, oReqY  out  cAddrW  window start address.
- oReqKerWidth  out  cKerW  latched kernel width.
- iIm2ColDone  in  1  one-cycle done pulse from im2col.
- oBusy  out  1  high in any state other than IDLE.
- oFrameDone  out  1  one-cycle pulse when the last window completes.
- oCfgErr  out  1  one-cycle pulse when iStart is rejected.
- oWdogErr  out  1  sticky; cleared by the next accepted iStart.
- oWinCount  out  16  windows completed in the current or last frame.

## Operation
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - On iStart, validate the config: ker ≥ 1, ker ≤ cMaxKerWidth, stride ≥ 1, ker ≤ iImgW, ker ≤ iImgH.
  - Invalid config: pulse oCfgErr and stay in IDLE.
  - Valid config: latch all config, set x = y = 0, clear oWinCount and oWdogErr, go to ISSUE.
- ISSUE: drive oReqDv = 1 for exactly one cycle, load the watchdog counter, go to WAIT.
- WAIT:
  - On iIm2ColDone: increment oWinCount.
  - If x + stride + ker ≤ imgW, then x += stride and go to ISSUE.
  - Else if y + stride + ker ≤ imgH, then x = 0, y += stride and go to ISSUE.
  - Otherwise go to FIN.
  - Compute the comparisons at cAddrW+2 bits so they never wrap.
- FIN: pulse oFrameDone for one cycle, go to IDLE.
- Watchdog: counts down in WAIT. At zero with no done, set oWdogErr and go to IDLE without a frame-done pulse.
- iAbort in any state: go to IDLE next cycle. oReqDv is forced low, oWinCount holds, no oFrameDone.
- iStart outside IDLE is ignored.
- A done pulse arriving outside WAIT is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, oReqX/oReqY/oReqKerWidth 0.
- iStart to first oReqDv: 1 cycle (iStart at cycle t, oReqDv at t+1).
- iIm2ColDone at cycle t gives the next oReqDv at t+1. No request is ever issued while im2col is busy.
- oReqX, oReqY and oReqKerWidth are registered and stable from the oReqDv cycle until the next ISSUE.
- Last iIm2ColDone at cycle t: FIN at t+1, oFrameDone at t+1, oBusy low at t+2.
- If iAbort and iIm2ColDone coincide, abort wins and the window is not counted.
- Reset may assert asynchronously mid-frame. All state clears immediately, and no pulse outputs glitch high after release.

## Structure
- Put tSchedState, a tSchedCfg struct and cWdogCycles in im2ColPckg, next to tIm2ColIn, so the top level can map the oReq* fields onto tIm2ColIn directly.
- Use the shared log2 from funcPckg.
- One sub-module is natural: win_stepper. It is combinational next-x/next-y/last-window logic with registered x/y, reused later by the pooling scheduler.

## Test plan
- 4×4 image, ker 3, stride 1, im2col model returning done 4 cycles after dv -> requests (0,0), (1,0), (0,1), (1,1); oWinCount = 4; one oFrameDone.
- 5×5 image, ker 2, stride 3 -> requests (0,0), (3,0), (0,3), (3,3); no request at x = 6.
- ker 4 with 3×8 image, and stride 0 -> oCfgErr pulse, oBusy stays low, no oReqDv.
- Done withheld for cWdogCycles -> oWdogErr = 1, state IDLE, no oFrameDone. The next valid iStart clears oWdogErr.
- iAbort asserted in WAIT of the 2nd window, with done in the same cycle -> IDLE, oWinCount = 1, later done ignored.
- iRstN low mid-frame for 1 cycle -> all outputs 0 immediately. Then iStart -> fresh frame from (0,0).
